// File: rtl/bias_seq_pkg.sv
// Shared types and constants for the bias DAC sequencer.
// Also holds the enabled-register scan used to pick the next word.
package bias_seq_pkg;

  localparam int unsigned WORD_BITS = 10;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SCAN_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] idx;
  } reg_sel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bias_word_t;

  // Lowest enabled register index that is >= from; found=0 when none remain.
  function automatic reg_sel_t pick_next(input logic [NUM_REGS-1:0] mask,
                                         input logic [SCAN_W-1:0]   from);
    reg_sel_t sel;
    sel = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[ADDR_W'(i)] && (SCAN_W'(i) >= from)) begin
        sel.found = 1'b1;
        sel.idx   = ADDR_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/bias_word_shifter.sv
// Serialises one 10-bit bias word MSB first: scl low then high for CLK_DIV
// cycles per bit, sda changes only as a low phase begins, cs_n frames the word.
module bias_word_shifter
  import bias_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [WORD_BITS-1:0] word,
  output logic                 scl,
  output logic                 sda,
  output logic                 cs_n,
  output logic                 word_done_c
);

  localparam int unsigned HALF_W = 8;
  localparam int unsigned BIT_W  = 4;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);

  logic                 active_q;
  logic                 high_q;
  logic [HALF_W-1:0]    half_q;
  logic [BIT_W-1:0]     bit_q;
  logic [WORD_BITS-1:0] shreg_q;
  logic                 half_end_c;

  assign half_end_c  = active_q && (half_q == HALF_LAST);
  assign word_done_c = half_end_c && high_q && (bit_q == BIT_LAST);

  // Half-period and bit counters reload per bit and per word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      scl      <= 1'b0;
      sda      <= 1'b0;
      cs_n     <= 1'b1;
    end else if (clear) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      scl      <= 1'b0;
      sda      <= 1'b0;
      cs_n     <= 1'b1;
    end else if (load) begin
      active_q <= 1'b1;
      high_q   <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= {word[WORD_BITS-2:0], 1'b0};
      scl      <= 1'b0;
      sda      <= word[WORD_BITS-1];
      cs_n     <= 1'b0;
    end else if (active_q) begin
      if (!half_end_c) begin
        half_q <= half_q + HALF_W'(1);
      end else begin
        half_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          scl    <= 1'b1;
        end else if (word_done_c) begin
          active_q <= 1'b0;
          high_q   <= 1'b0;
          scl      <= 1'b0;
          sda      <= 1'b0;
          cs_n     <= 1'b1;
        end else begin
          high_q  <= 1'b0;
          scl     <= 1'b0;
          bit_q   <= bit_q + BIT_W'(1);
          sda     <= shreg_q[WORD_BITS-1];
          shreg_q <= {shreg_q[WORD_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/bias_dac_sequencer.sv
// Programs up to four bias registers over a 3-wire serial link, one framed
// word per enabled register, with a cs_n-high gap between consecutive words.
module bias_dac_sequencer
  import bias_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_REGS-1:0]        reg_mask,
  input  logic [NUM_REGS*DATA_W-1:0] bias_data,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          word_idx,
  output logic                       scl,
  output logic                       sda,
  output logic                       cs_n
);

  localparam int unsigned GAP_W = 10;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [NUM_REGS-1:0]         mask_q, mask_d;
  logic [NUM_REGS*DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]           idx_q, idx_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic                        busy_d, done_d;
  logic                        load_c, clear_c, word_done_c;
  bias_word_t                  word_c;
  reg_sel_t                    first_sel_c, next_sel_c;

  assign first_sel_c = pick_next(reg_mask, '0);
  assign next_sel_c  = pick_next(mask_q, SCAN_W'(idx_q) + SCAN_W'(1));
  assign word_idx    = idx_q;

  // State and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, word selection and shifter handshake.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    load_c  = 1'b0;
    clear_c = 1'b0;
    word_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = reg_mask;
          data_d = bias_data;
          if (first_sel_c.found) begin
            state_d     = ST_SHIFT;
            idx_d       = first_sel_c.idx;
            load_c      = 1'b1;
            word_c.addr = first_sel_c.idx;
            word_c.data = bias_data[DATA_W*first_sel_c.idx +: DATA_W];
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          clear_c = 1'b1;
          state_d = ST_IDLE;
        end else if (word_done_c) begin
          if (next_sel_c.found) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          clear_c = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d     = ST_SHIFT;
          idx_d       = next_sel_c.idx;
          load_c      = 1'b1;
          word_c.addr = next_sel_c.idx;
          word_c.data = data_q[DATA_W*next_sel_c.idx +: DATA_W];
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  bias_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load_c),
    .clear       (clear_c),
    .word        (word_c),
    .scl         (scl),
    .sda         (sda),
    .cs_n        (cs_n),
    .word_done_c (word_done_c)
  );

endmodule

// File: tb/tb_bias_dac_sequencer.sv
// Directed bench for bias_dac_sequencer: table of full sequences plus
// hand-written abort, reset-in-gap, snapshot-hold and start/abort cases.
module tb_bias_dac_sequencer;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 10;
  localparam int WORD_CYC = 20 * CLK_DIV;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic [3:0]  reg_mask  = '0;
  logic [31:0] bias_data = '0;
  logic        busy, done, scl, sda, cs_n;
  logic [1:0]  word_idx;

  int n_checks = 0;
  int n_pass   = 0;

  bias_dac_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .reg_mask  (reg_mask),
    .bias_data (bias_data),
    .busy      (busy),
    .done      (done),
    .word_idx  (word_idx),
    .scl       (scl),
    .sda       (sda),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       mask;
    logic [31:0]      data;
    int               nwords;
    logic [3:0][9:0]  w;
    logic [3:0][1:0]  ix;
    int               done_off;
  } vec_t;

  vec_t vecs[6];

  // Observed link activity, sampled once per cycle on the falling edge.
  int         cyc = 0;
  logic       prev_scl = 1'b0, prev_sda = 1'b0, prev_cs = 1'b1;
  logic [9:0] cur_bits = '0;
  logic [9:0] words[$];
  logic [1:0] idxs[$];
  int         falls[$];
  int         rises[$];
  int         rise_cnt, done_cnt, done_cyc, stab_err, scl_idle_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] mask, input logic [31:0] data,
                              input int nwords,
                              input logic [9:0] w0, input logic [9:0] w1,
                              input logic [9:0] w2, input logic [9:0] w3,
                              input logic [1:0] i0, input logic [1:0] i1,
                              input logic [1:0] i2, input logic [1:0] i3,
                              input int done_off);
    vec_t v;
    v.mask = mask; v.data = data; v.nwords = nwords;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.ix[0] = i0; v.ix[1] = i1; v.ix[2] = i2; v.ix[3] = i3;
    v.done_off = done_off;
    return v;
  endfunction

  task automatic mon_clear();
    words.delete(); idxs.delete(); falls.delete(); rises.delete();
    rise_cnt = 0; done_cnt = 0; done_cyc = -1; stab_err = 0; scl_idle_err = 0;
  endtask

  task automatic sample();
    cyc++;
    if (!cs_n && prev_cs) begin
      falls.push_back(cyc);
      idxs.push_back(word_idx);
      cur_bits = '0;
    end
    if (scl && !prev_scl) begin
      cur_bits = {cur_bits[8:0], sda};
      rise_cnt++;
      if (sda !== prev_sda) stab_err++;
    end
    if (cs_n && !prev_cs) begin
      rises.push_back(cyc);
      words.push_back(cur_bits);
    end
    if (scl && cs_n) scl_idle_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_scl = scl; prev_sda = sda; prev_cs = cs_n;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic wait_done(input string name);
    int b;
    b = 0;
    while (done_cnt == 0 && b < 2000) begin tick(); b++; end
    check({name, "_done_seen"}, (done_cnt > 0), 1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int s;
    string nm;
    nm = $sformatf("v%0d", n);
    mon_clear();
    reg_mask = v.mask; bias_data = v.data; start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    check({nm, "_busy_first"}, busy, (v.nwords != 0));
    check({nm, "_csn_first"}, cs_n, (v.nwords == 0));
    wait_done(nm);
    repeat (20) tick();
    check({nm, "_done_count"}, done_cnt, 1);
    check({nm, "_done_offset"}, done_cyc - s, v.done_off);
    check({nm, "_word_count"}, words.size(), v.nwords);
    for (int i = 0; i < v.nwords && i < words.size(); i++) begin
      check($sformatf("%s_word%0d", nm, i), words[i], v.w[i]);
      check($sformatf("%s_idx%0d", nm, i), idxs[i], v.ix[i]);
      check($sformatf("%s_csn_low%0d", nm, i), rises[i] - falls[i], WORD_CYC);
      if (i > 0) check($sformatf("%s_gap%0d", nm, i), falls[i] - rises[i-1], GAP_CYCLES);
    end
    check({nm, "_scl_rises"}, rise_cnt, 10 * v.nwords);
    check({nm, "_sda_stable"}, stab_err, 0);
    check({nm, "_scl_outside_cs"}, scl_idle_err, 0);
    if (v.nwords != 0) check({nm, "_word_idx_hold"}, word_idx, v.ix[v.nwords-1]);
  endtask

  initial begin
    int b;
    int s;

    vecs[0] = mk(4'b0001, 32'h0000_0080, 1, 10'h080, 10'h000, 10'h000, 10'h000,
                 2'd0, 2'd0, 2'd0, 2'd0, 80);
    vecs[1] = mk(4'b1010, 32'hC300_5A00, 2, 10'h15A, 10'h3C3, 10'h000, 10'h000,
                 2'd1, 2'd3, 2'd0, 2'd0, 170);
    vecs[2] = mk(4'b0000, 32'hDEAD_BEEF, 0, 10'h000, 10'h000, 10'h000, 10'h000,
                 2'd0, 2'd0, 2'd0, 2'd0, 0);
    vecs[3] = mk(4'b1111, 32'h01FF_00A5, 4, 10'h0A5, 10'h100, 10'h2FF, 10'h301,
                 2'd0, 2'd1, 2'd2, 2'd3, 350);
    vecs[4] = mk(4'b0100, 32'hFF3C_FFFF, 1, 10'h23C, 10'h000, 10'h000, 10'h000,
                 2'd2, 2'd0, 2'd0, 2'd0, 80);
    vecs[5] = mk(4'b1001, 32'h7E00_0081, 2, 10'h081, 10'h37E, 10'h000, 10'h000,
                 2'd0, 2'd3, 2'd0, 2'd0, 170);

    mon_clear();
    repeat (2) @(negedge clk);
    check("rst_scl", scl, 0);
    check("rst_sda", sda, 0);
    check("rst_csn", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_idx", word_idx, 0);
    reset_n = 1'b1;

    // abort while idle does nothing
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_csn", cs_n, 1);
    check("idle_abort_done", done_cnt, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // abort during the 5th bit of word 0
    mon_clear();
    reg_mask = 4'hF; bias_data = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    while (!(rise_cnt == 4 && scl == 1'b0) && b < 500) begin tick(); b++; end
    check("abort_reach_bit5", (b < 500), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_csn", cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_scl", scl, 0);
    check("abort_sda", sda, 0);
    repeat (100) tick();
    check("abort_no_more_scl", rise_cnt, 4);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_new_word", falls.size(), 1);

    // asynchronous reset during the gap
    mon_clear();
    reg_mask = 4'b0110; bias_data = 32'h0077_AB00; start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    while (rises.size() == 0 && b < 500) begin tick(); b++; end
    check("rstgap_reach_gap", rises.size(), 1);
    repeat (3) tick();
    check("rstgap_idx_before", word_idx, 1);
    check("rstgap_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstgap_scl", scl, 0);
    check("rstgap_sda", sda, 0);
    check("rstgap_csn", cs_n, 1);
    check("rstgap_busy", busy, 0);
    check("rstgap_done", done, 0);
    check("rstgap_word_idx", word_idx, 0);
    repeat (3) tick();
    check("rstgap_no_done", done_cnt, 0);
    check("rstgap_no_second_word", falls.size(), 1);
    reset_n = 1'b1;
    run_vec(vecs[1], 10);

    // snapshot held; restarts mid-word and mid-gap ignored
    mon_clear();
    reg_mask = 4'b0011; bias_data = 32'h0000_3355; start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    repeat (30) tick();
    bias_data = 32'hFFFF_FFFF; reg_mask = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    while (rises.size() == 0 && b < 500) begin tick(); b++; end
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("snap");
    repeat (20) tick();
    check("snap_word_count", words.size(), 2);
    if (words.size() == 2) begin
      check("snap_word0", words[0], 10'h055);
      check("snap_word1", words[1], 10'h133);
    end
    check("snap_done_count", done_cnt, 1);
    check("snap_done_offset", done_cyc - s, 170);

    // start and abort together while idle: start wins
    mon_clear();
    reg_mask = 4'b0001; bias_data = 32'h0000_0080; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", busy, 1);
    check("startabort_csn", cs_n, 0);
    wait_done("startabort");
    repeat (5) tick();
    check("startabort_word_count", words.size(), 1);
    if (words.size() == 1) check("startabort_word", words[0], 10'h080);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
